// File: rtl/ram_read_checker.sv
// ram_read_checker: checks RAM read passes against base+addr written in the preceding write pass.
// Optional CHK_CLEAR_EN adds a synchronous clr that zeroes the error/pass statistics.
module ram_read_checker #(
  parameter int DW         = 8,
  parameter int AW         = 8,
  parameter int RD_LATENCY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CHK_CLEAR_EN
  input  logic             clr,
`endif
  input  logic             wren,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    data,
  input  logic [DW-1:0]    q,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [AW-1:0]    first_err_addr,
  output logic [DW-1:0]    first_err_data,
  output logic [CNT_W-1:0] pass_count,
  output logic             pass_done,
  output logic             pass_ok
);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state, state_nx;
  logic armed, issue, base_ld, clr_i, cv, mis, last, pass_err;
  logic [DW-1:0] base;
  logic          pv [RD_LATENCY];
  logic [AW-1:0] pa [RD_LATENCY];
  logic [DW-1:0] pe [RD_LATENCY];
`ifdef CHK_CLEAR_EN
  assign clr_i = clr;
`else
  assign clr_i = 1'b0;
`endif
  assign base_ld = wren && addr == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = (state == IDLE && base_ld) ? ARMED : state;
  always_comb armed = state == ARMED;
  assign issue = armed && !wren;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) base <= '0;
    else if (base_ld) base <= data;
  // expected value is frozen at issue so a base reload cannot disturb in-flight reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
        pe[i] <= '0;
      end
    end else begin
      pv[0] <= issue;
      pa[0] <= addr;
      pe[0] <= base + DW'(addr);
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pe[i] <= pe[i-1];
      end
    end
  assign cv   = pv[RD_LATENCY-1];
  assign mis  = cv && q != pe[RD_LATENCY-1];
  assign last = cv && pa[RD_LATENCY-1] == '1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err            <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass_count     <= '0;
      pass_done      <= 1'b0;
      pass_ok        <= 1'b0;
      pass_err       <= 1'b0;
    end else begin
      pass_done <= last;
      pass_ok   <= last && !pass_err && !mis;
      if (clr_i) begin
        err            <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
        pass_count     <= '0;
        pass_err       <= 1'b0;
      end else begin
        if (mis) begin
          err <= 1'b1;
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          if (!err) begin
            first_err_addr <= pa[RD_LATENCY-1];
            first_err_data <= q;
          end
        end
        if (last) pass_count <= pass_count + CNT_W'(1);
        pass_err <= !last && (pass_err || mis);
      end
    end
endmodule

// File: doc/ram_read_checker.md
Name: ram_read_checker

Overview:
- Sits directly downstream of the on-chip RAM and its write/read sequencing controller.
- Snoops the controller's wren/addr/data bus and the RAM's q output.
- Checks every read word against the value written in the preceding write pass; reports errors and completed passes.
- Expected-data model: word at address a = base + a (mod 2^DW), where base is the data written to address 0 in the current write pass.

Parameters:
- DW, 8, data width of data and q.
- AW, 8, address width; a pass ends at address 2^AW-1.
- RD_LATENCY, 2, clocks from a read cycle on the bus to valid q. Legal range 1..4.
- CNT_W, 16, width of err_count and pass_count.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wren  input  1  controller write enable; 0 = read cycle
- addr  input  AW  controller address
- data  input  DW  controller write data
- q  input  DW  RAM read data
- err  output  1  sticky: at least one mismatch since reset
- err_count  output  CNT_W  total mismatches, saturating at all-ones
- first_err_addr  output  AW  address of the first mismatch
- first_err_data  output  DW  q value of the first mismatch
- pass_count  output  CNT_W  completed read passes, wrapping
- pass_done  output  1  one-clock pulse when a read of address 2^AW-1 is compared
- pass_ok  output  1  one-clock pulse with pass_done if that pass had no mismatch

Behaviour:
- Reset:
  - Every output is 0.
  - Pipeline valid bits are cleared, base = 0, state = IDLE.
  - Reset mid-pass discards all in-flight compares; no pulse follows.
- States:
  - IDLE: not armed. Read cycles are ignored, which covers the uninitialised-RAM read seen right after reset.
  - IDLE -> ARMED: on the first cycle with wren=1 and addr=0. base <= data on that cycle.
  - ARMED: stays ARMED until reset. Every cycle with wren=1 and addr=0 reloads base.
- Issue (ARMED, wren=0):
  - Push valid=1, addr, and exp = (base + addr) mod 2^DW into a RD_LATENCY-deep shift pipeline.
  - Otherwise push valid=0.
  - exp is computed from the base at issue time. Reads still in flight when a new write pass reloads base must compare against the old base.
- Compare (pipeline output valid, same cycle as q):
  - Mismatch when q != exp.
  - On mismatch: err <= 1; err_count increments, holding at all-ones.
  - On the first mismatch since reset only: first_err_addr <= addr, first_err_data <= q. Later mismatches never overwrite them.
  - pass_err (internal) is set on any mismatch.
- Pass completion (compared entry has addr = 2^AW-1):
  - pass_done = 1 for exactly one cycle.
  - pass_ok = 1 in the same cycle if the pass had no mismatch, including a mismatch on this final compare.
  - pass_count increments, wrapping.
  - pass_err clears for the next pass.
- Output timing: all outputs are registered and update one clock after the compare cycle. Compare-to-flag latency = 1; bus-to-flag latency = RD_LATENCY + 1.
- Partial pass: a read sequence that never reaches the top address produces no pulse. Its mismatches still count.
- Simultaneous events: a base reload and a compare in the same cycle are independent; the compare uses its pipelined exp.
- Throughput: one compare per clock.

Optional Feature:
- Macro: CHK_CLEAR_EN.
- Defined:
  - Adds input port clr (1 bit, synchronous, active-high).
  - clr=1 zeroes err, err_count, first_err_addr, first_err_data, pass_count and pass_err.
  - It leaves state, base and pipeline untouched.
  - A mismatch in the same cycle as clr is dropped; clear wins.
- Undefined: no clr port; counters clear only by rst_n.

Test Plan:
- Reset, 3 read cycles, then write 0..255 with data=addr, then read 0..255 with q model correct -> no compares before arming; pass_done and pass_ok pulse once, pass_count=1, err=0.
- Second write pass with base=128 (addr 255 data 127), then read -> all match, pass_count=2. The last reads of pass 1 still in flight when base reloads compare against base 0.
- Corrupt q to 0x55 at addr 7 and 0xAA at addr 9 in one pass -> err=1, err_count=2, first_err_addr=7, first_err_data=0x55, pass_done=1, pass_ok=0. The next clean pass gives pass_ok=1.
- RD_LATENCY=1 and RD_LATENCY=4 builds with the same stimulus -> flags arrive RD_LATENCY+1 clocks after the addr-255 read, identical counts.
- Assert rst_n at read addr 100, then rerun the sequence -> outputs 0, no pulse from the aborted pass, and a read-before-write after reset is ignored.
- With CHK_CLEAR_EN defined: inject error, pulse clr -> err=0, err_count=0, first_err fields 0. The next mismatch recaptures the first_err fields.
